wf_gather_ctrl: RTL and testbench

Flow-control front end for the 8-entry wavefront gather RAM. Accepts 38-bit wavefront records from the upstream dispatch path over a valid/ready handshake and writes them into the RAM's write port. Issues reads on the RAM's 1-cycle-latency read port and presents records in FIFO order to the downstream consumer over a second valid/ready handshake. Holds all pointers and occupancy; the RAM itself stays a plain storage macro.

---
 rtl/wf_gather_pkg.sv | 14 +
 rtl/wf_gather_ctrl_if.sv | 33 +++
 rtl/wf_gather_ctrl.sv | 115 +++++++++++
 tb/tb_wf_gather_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wf_gather_pkg.sv
// Shared constants and types for the wavefront gather RAM front end.
// Holds depth/width parameters and the output-stage state encoding.
package wf_gather_pkg;

  localparam int WF_GATHER_DEPTH  = 8;
  localparam int WF_GATHER_ADDR_W = 3;
  localparam int WF_GATHER_DATA_W = 38;

  typedef enum logic {
    EMPTY = 1'b0,
    VALID = 1'b1
  } out_state_e;

endpackage

// File: rtl/wf_gather_ctrl_if.sv
// Bus bundle for wf_gather_ctrl: upstream and downstream valid/ready
// handshakes plus the gather RAM write/read ports. slave = controller view.
interface wf_gather_ctrl_if;
  import wf_gather_pkg::*;

  logic                        in_valid;
  logic                        in_ready;
  logic [WF_GATHER_DATA_W-1:0] in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [WF_GATHER_DATA_W-1:0] out_data;
  logic                        ram_w_en;
  logic [WF_GATHER_ADDR_W-1:0] ram_w_addr;
  logic [WF_GATHER_DATA_W-1:0] ram_w_data;
  logic                        ram_r_en;
  logic [WF_GATHER_ADDR_W-1:0] ram_r_addr;
  logic [WF_GATHER_DATA_W-1:0] ram_r_data;

  modport slave (
    input  in_valid, in_data, out_ready, ram_r_data,
    output in_ready, out_valid, out_data,
    output ram_w_en, ram_w_addr, ram_w_data,
    output ram_r_en, ram_r_addr
  );

  modport master (
    output in_valid, in_data, out_ready, ram_r_data,
    input  in_ready, out_valid, out_data,
    input  ram_w_en, ram_w_addr, ram_w_data,
    input  ram_r_en, ram_r_addr
  );

endinterface

// File: rtl/wf_gather_ctrl.sv
// Flow-control front end for the 8-entry gather RAM: pointers, occupancy,
// 1-cycle read prefetch and FIFO-ordered output over valid/ready.
// Ports: clock, reset (async high), flush (sync clear), bus (slave).
// WF_GATHER_CTRL_STATS_EN adds stat_push_cnt and stat_max_occ outputs.
module wf_gather_ctrl
  import wf_gather_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
`ifdef WF_GATHER_CTRL_STATS_EN
  output logic [15:0]               stat_push_cnt,
  output logic [WF_GATHER_ADDR_W:0] stat_max_occ,
`endif
  wf_gather_ctrl_if.slave           bus
);

  localparam int AW = WF_GATHER_ADDR_W;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(WF_GATHER_DEPTH);

  out_state_e  state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [AW:0]   unread_q, unread_d;

  logic in_ready;
  logic out_valid;
  logic push;
  logic pop;
  logic fetch;

`ifdef WF_GATHER_CTRL_STATS_EN
  logic [15:0] push_cnt_q, push_cnt_d;
  logic [AW:0] max_occ_q, max_occ_d;
`endif

  always_comb begin
    in_ready  = (occ_q != OCC_FULL) & ~flush;
    out_valid = (state_q == VALID);
    push      = bus.in_valid & in_ready & ~reset;
    pop       = out_valid & bus.out_ready & ~flush;
    // Only entries already written count; a same-cycle
    // push is never forwarded to the read port.
    fetch     = (unread_q != '0)
              & ((state_q == EMPTY) | bus.out_ready)
              & ~flush & ~reset;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(fetch);
    occ_d    = occ_q + (AW+1)'(push) - (AW+1)'(pop);
    unread_d = unread_q + (AW+1)'(push) - (AW+1)'(fetch);
    state_d  = state_q;
    unique case (state_q)
      EMPTY: if (fetch) state_d = VALID;
      VALID: if (pop && !fetch) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      unread_d = '0;
      state_d  = EMPTY;
    end
  end

`ifdef WF_GATHER_CTRL_STATS_EN
  always_comb begin
    push_cnt_d = push_cnt_q + 16'(push);
    max_occ_d  = (occ_d > max_occ_q) ? occ_d : max_occ_q;
  end

  assign stat_push_cnt = push_cnt_q;
  assign stat_max_occ  = max_occ_q;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      unread_q <= '0;
`ifdef WF_GATHER_CTRL_STATS_EN
      push_cnt_q <= '0;
      max_occ_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      unread_q <= unread_d;
`ifdef WF_GATHER_CTRL_STATS_EN
      push_cnt_q <= push_cnt_d;
      max_occ_q  <= max_occ_d;
`endif
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  // RAM holds its read data while ram_r_en is low,
  // so a stalled record stays stable without a local copy.
  assign bus.out_data   = bus.ram_r_data;
  assign bus.ram_w_en   = push;
  assign bus.ram_w_addr = wr_ptr_q;
  assign bus.ram_w_data = bus.in_data;
  assign bus.ram_r_en   = fetch;
  assign bus.ram_r_addr = rd_ptr_q;

endmodule

// File: tb/tb_wf_gather_ctrl.sv
// Self-checking bench for wf_gather_ctrl with a behavioural gather RAM.
// Table-driven cycle vectors plus hand-written stream/reset sequences.
module tb_wf_gather_ctrl;
  import wf_gather_pkg::*;

  typedef logic [37:0] dat_t;

  typedef struct {
    logic       rst, fl, iv, ordy;
    dat_t       din;
    logic       ird, ov;
    dat_t       dat;
    logic       wen;
    logic [2:0] waddr;
    logic       ren;
    logic [2:0] raddr;
    string      name;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vecs[$];

  wf_gather_ctrl_if bus ();

`ifdef WF_GATHER_CTRL_STATS_EN
  logic [15:0] stat_push_cnt;
  logic [3:0]  stat_max_occ;
  wf_gather_ctrl dut (
    .clock(clock), .reset(reset), .flush(flush),
    .stat_push_cnt(stat_push_cnt),
    .stat_max_occ(stat_max_occ),
    .bus(bus)
  );
`else
  wf_gather_ctrl dut (
    .clock(clock), .reset(reset), .flush(flush),
    .bus(bus)
  );
`endif

  always #5 clock = ~clock;

  dat_t mem [8];
  dat_t rdat = '0;
  always @(posedge clock) begin
    if (bus.ram_w_en) mem[bus.ram_w_addr] <= bus.ram_w_data;
    if (bus.ram_r_en) rdat <= mem[bus.ram_r_addr];
  end
  assign bus.ram_r_data = rdat;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void add(
    logic rst, logic fl, logic iv, logic ordy, dat_t din,
    logic ird, logic ov, dat_t dat,
    logic wen, int waddr, logic ren, int raddr, string nm);
    vec_t v;
    v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy;
    v.din = din; v.ird = ird; v.ov = ov; v.dat = dat;
    v.wen = wen; v.waddr = 3'(waddr);
    v.ren = ren; v.raddr = 3'(raddr); v.name = nm;
    vecs.push_back(v);
  endfunction

  function automatic dat_t dd(int i);
    return dat_t'(38'h10_0000_0000 + i);
  endfunction

  function automatic dat_t ff(int i);
    return dat_t'(38'h20_0000_0000 + i);
  endfunction

  task automatic drive(logic iv, dat_t d, logic ordy);
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  task automatic fill8(string nm, bit useff);
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, 0, useff ? ff(i) : dd(i),
          1, i >= 2, useff ? ff(0) : dd(0),
          1, i, i == 1, 0, nm);
  endtask

  initial begin
    dat_t a1, x, prev;
    int sent, recv, cyc;
    bit pstall;

    drive(0, '0, 0);

    // reset state, with in_valid high
    add(1, 0, 1, 0, '1, 1, 0, '0, 0, 0, 0, 0, "rst");
    // single record latency
    a1 = 38'h2A_0000_0001;
    add(0, 0, 1, 1, a1, 1, 0, '0, 1, 0, 0, 0, "t1c0");
    add(0, 0, 0, 1, '0, 1, 0, '0, 0, 0, 1, 0, "t1c1");
    add(0, 0, 0, 1, '0, 1, 1, a1, 0, 0, 0, 0, "t1c2");
    add(0, 0, 0, 1, '0, 1, 0, '0, 0, 0, 0, 0, "t1c3");
    add(0, 1, 0, 0, '0, 0, 0, '0, 0, 0, 0, 0, "fl0");
    // fill to full, 9th rejected, drain in order
    fill8("t2fill", 0);
    add(0, 0, 1, 0, 38'h3F_DEAD, 0, 1, dd(0),
        0, 0, 0, 0, "t2ninth");
    for (int j = 0; j < 8; j++)
      add(0, 0, 0, 1, '0, j > 0, 1, dd(j),
          0, 0, j < 7, j + 1, "t2pop");
    // full with pop+push request: no push, then push wraps
    fill8("t3fill", 1);
    x = 38'h30_0000_0030;
    add(0, 0, 1, 1, x, 0, 1, ff(0), 0, 0, 1, 1, "t3col");
    add(0, 0, 1, 0, x, 1, 1, ff(1), 1, 0, 0, 0, "t3push");
    for (int j = 0; j < 8; j++)
      add(0, 0, 0, 1, '0, j > 0, 1, j < 7 ? ff(j + 1) : x,
          0, 0, j < 7, (j + 2) % 8, "t3pop");
    // flush with occ=5, out_valid=1 and in_valid=1
    for (int i = 0; i < 5; i++)
      add(0, 0, 1, 0, dd(i + 8), 1, i >= 2, dd(8),
          1, i + 1, i == 1, 1, "t5fill");
    add(0, 1, 1, 0, 38'h3F_BEEF, 0, 1, dd(8),
        0, 0, 0, 0, "t5flush");
    add(0, 0, 0, 0, '0, 1, 0, '0, 0, 0, 0, 0, "t5after");
    add(0, 0, 1, 0, dd(20), 1, 0, '0, 1, 0, 0, 0, "t5push");
    add(0, 0, 0, 0, '0, 1, 0, '0, 0, 0, 1, 0, "t5fetch");
    add(0, 0, 0, 1, '0, 1, 1, dd(20), 0, 0, 0, 0, "t5pop");
    add(0, 0, 0, 1, '0, 1, 0, '0, 0, 0, 0, 0, "t5idle");

    foreach (vecs[k]) begin
      @(negedge clock);
      reset = vecs[k].rst;
      flush = vecs[k].fl;
      drive(vecs[k].iv, vecs[k].din, vecs[k].ordy);
      #1;
      chk({vecs[k].name, ".in_ready"}, 64'(bus.in_ready),
          64'(vecs[k].ird));
      chk({vecs[k].name, ".out_valid"}, 64'(bus.out_valid),
          64'(vecs[k].ov));
      if (vecs[k].ov)
        chk({vecs[k].name, ".out_data"}, 64'(bus.out_data),
            64'(vecs[k].dat));
      chk({vecs[k].name, ".w_en"}, 64'(bus.ram_w_en),
          64'(vecs[k].wen));
      if (vecs[k].wen)
        chk({vecs[k].name, ".w_addr"}, 64'(bus.ram_w_addr),
            64'(vecs[k].waddr));
      chk({vecs[k].name, ".r_en"}, 64'(bus.ram_r_en),
          64'(vecs[k].ren));
      if (vecs[k].ren)
        chk({vecs[k].name, ".r_addr"}, 64'(bus.ram_r_addr),
            64'(vecs[k].raddr));
    end

    // 20-record stream with out_ready toggling every cycle
    sent = 0; recv = 0; pstall = 0; prev = '0;
    for (cyc = 0; cyc < 300 && recv < 20; cyc++) begin
      @(negedge clock);
      drive(sent < 20, ff(40 + sent), cyc[0]);
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
      if (pstall)
        chk("stall_hold", 64'(bus.out_data), 64'(prev));
      if (bus.out_valid && bus.out_ready) begin
        chk("stream_data", 64'(bus.out_data), 64'(ff(40 + recv)));
        recv++;
      end
      pstall = bus.out_valid && !bus.out_ready;
      prev   = bus.out_data;
    end
    chk("stream_count", 64'(recv), 64'd20);
    @(negedge clock);
    drive(0, '0, 1);
    #1;
    chk("stream_drained", 64'(bus.out_valid), 64'd0);

    // reset mid-transfer discards contents
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      drive(1, dd(60 + i), 0);
    end
    @(negedge clock);
    reset = 1'b1;
    drive(1, dd(70), 1);
    #1;
    chk("mrst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("mrst.in_ready", 64'(bus.in_ready), 64'd1);
    chk("mrst.w_en", 64'(bus.ram_w_en), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    drive(0, '0, 1);
    repeat (3) @(negedge clock);
    #1;
    chk("mrst.no_ghost", 64'(bus.out_valid), 64'd0);
    chk("mrst.r_en", 64'(bus.ram_r_en), 64'd0);

`ifdef WF_GATHER_CTRL_STATS_EN
    // push counter and high-water mark, measured from reset
    sent = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      drive(1, dd(i), 0);
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
    end
    @(negedge clock);
    drive(0, '0, 0);
    #1;
    chk("stat_max6", 64'(stat_max_occ), 64'd6);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    #1;
    chk("stat_max_kept", 64'(stat_max_occ), 64'd6);
    for (cyc = 0; cyc < 80000 && sent < 70000; cyc++) begin
      @(negedge clock);
      drive(1, dd(sent), 1);
      #1;
      if (bus.in_valid && bus.in_ready) sent++;
    end
    chk("stat_sent", 64'(sent), 64'd70000);
    @(negedge clock);
    drive(0, '0, 1);
    repeat (4) @(negedge clock);
    #1;
    chk("stat_push_cnt", 64'(stat_push_cnt), 64'd4464);
    chk("stat_max_final", 64'(stat_max_occ), 64'd6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
